// File: rtl/ex_stage_pkg.sv
// Shared codes, bus types and divider state encodings for the execute stage.
package ex_stage_pkg;

  typedef logic [7:0]  ALUOP_BUS;
  typedef logic [2:0]  ALUSEL_BUS;
  typedef logic [31:0] REG_BUS;
  typedef logic [4:0]  REG_ADDR_BUS;
  typedef logic [5:0]  STALL_BUS;

  localparam REG_BUS ZERO_WORD = 32'h0000_0000;

  // Operation codes
  localparam ALUOP_BUS ALUOP_NOP  = 8'h00;
  localparam ALUOP_BUS ALUOP_ADD  = 8'h01;
  localparam ALUOP_BUS ALUOP_SUB  = 8'h02;
  localparam ALUOP_BUS ALUOP_AND  = 8'h03;
  localparam ALUOP_BUS ALUOP_OR   = 8'h04;
  localparam ALUOP_BUS ALUOP_XOR  = 8'h05;
  localparam ALUOP_BUS ALUOP_SLL  = 8'h06;
  localparam ALUOP_BUS ALUOP_SRL  = 8'h07;
  localparam ALUOP_BUS ALUOP_SRA  = 8'h08;
  localparam ALUOP_BUS ALUOP_SLT  = 8'h09;
  localparam ALUOP_BUS ALUOP_SLTU = 8'h0A;
  localparam ALUOP_BUS ALUOP_DIV  = 8'h10;
  localparam ALUOP_BUS ALUOP_DIVU = 8'h11;
  localparam ALUOP_BUS ALUOP_REM  = 8'h12;
  localparam ALUOP_BUS ALUOP_REMU = 8'h13;

  // Result-group selects
  localparam ALUSEL_BUS SEL_NOP   = 3'd0;
  localparam ALUSEL_BUS SEL_LOGIC = 3'd1;
  localparam ALUSEL_BUS SEL_SHIFT = 3'd2;
  localparam ALUSEL_BUS SEL_ARITH = 3'd3;
  localparam ALUSEL_BUS SEL_DIV   = 3'd4;

  // Bit of the stall vector that freezes EX
  localparam int STALL_EX_BIT = 3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input ALUOP_BUS op);
    case (op)
      ALUOP_DIV, ALUOP_DIVU, ALUOP_REM, ALUOP_REMU: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_div(input ALUOP_BUS op);
    case (op)
      ALUOP_DIV, ALUOP_REM: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider: one quotient bit per cycle, magnitudes in the
// datapath, signs re-applied on the last step. Divide-by-zero and signed
// overflow bypass the iteration with preset results.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] W_ZERO   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] W_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] W_ALL1   = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] W_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
    return ~v + W_ONE;
  endfunction

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] quot_q;      // holds |A| while shifting, quotient at the end
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] divisor_q;
  logic              q_neg_q;
  logic              r_neg_q;

  logic              a_neg_d;
  logic              b_neg_d;
  logic [DATA_W-1:0] a_mag_d;
  logic [DATA_W-1:0] b_mag_d;
  logic [DATA_W:0]   step_tmp_d;
  logic [DATA_W:0]   step_diff_d;
  logic              step_ge_d;
  logic [DATA_W-1:0] step_rem_d;
  logic [DATA_W-1:0] step_quot_d;

  assign a_neg_d = is_signed & op_a[DATA_W-1];
  assign b_neg_d = is_signed & op_b[DATA_W-1];
  assign a_mag_d = a_neg_d ? neg(op_a) : op_a;
  assign b_mag_d = b_neg_d ? neg(op_b) : op_b;

  // One restoring step: shift in next dividend bit, subtract if it fits
  assign step_tmp_d  = {rem_q, quot_q[DATA_W-1]};
  assign step_diff_d = step_tmp_d - {1'b0, divisor_q};
  assign step_ge_d   = ~step_diff_d[DATA_W];
  assign step_rem_d  = step_ge_d ? step_diff_d[DATA_W-1:0] : step_tmp_d[DATA_W-1:0];
  assign step_quot_d = {quot_q[DATA_W-2:0], step_ge_d};

  assign busy      = ((state_q == DIV_IDLE) & start) | (state_q == DIV_BUSY);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;

  // Divider FSM: latch operands, iterate, sign-correct, hold result until released
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= CNT_ZERO;
      quot_q    <= W_ZERO;
      rem_q     <= W_ZERO;
      divisor_q <= W_ZERO;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            cnt_q <= CNT_ZERO;
            if (op_b == W_ZERO) begin
              quot_q  <= W_ALL1;
              rem_q   <= op_a;
              state_q <= DIV_DONE;
            end else if (is_signed && (op_a == W_MIN) && (op_b == W_ALL1)) begin
              quot_q  <= W_MIN;
              rem_q   <= W_ZERO;
              state_q <= DIV_DONE;
            end else begin
              quot_q    <= a_mag_d;
              rem_q     <= W_ZERO;
              divisor_q <= b_mag_d;
              q_neg_q   <= a_neg_d ^ b_neg_d;
              r_neg_q   <= a_neg_d;
              state_q   <= DIV_BUSY;
            end
          end else begin
            state_q <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            quot_q  <= q_neg_q ? neg(step_quot_d) : step_quot_d;
            rem_q   <= r_neg_q ? neg(step_rem_d) : step_rem_d;
            state_q <= DIV_DONE;
          end else begin
            quot_q  <= step_quot_d;
            rem_q   <= step_rem_d;
            state_q <= DIV_BUSY;
          end
        end
        DIV_DONE: begin
          if (hold) begin
            state_q <= DIV_DONE;
          end else begin
            state_q <= DIV_IDLE;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU result mux plus the iterative divider,
// whose busy flag becomes the pipeline stall request.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ex_aluop,
  input  logic [2:0]        ex_alusel,
  input  logic [DATA_W-1:0] ex_rdata1,
  input  logic [DATA_W-1:0] ex_rdata2,
  input  logic [4:0]        ex_waddr,
  input  logic              ex_we,
  input  logic [5:0]        ctrl_stall,
  output logic              stall_req,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [4:0]        mem_waddr,
  output logic              mem_we
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] W_ZERO = {DATA_W{1'b0}};

  logic [SH_W-1:0]   shamt_s;
  logic [DATA_W-1:0] result_s;
  logic              div_start_s;
  logic              div_signed_s;
  logic              div_busy_s;
  logic              div_done_s;
  logic [DATA_W-1:0] div_quot_s;
  logic [DATA_W-1:0] div_rem_s;
  logic              unused_s;

  assign shamt_s      = ex_rdata2[SH_W-1:0];
  assign div_start_s  = (ex_alusel == SEL_DIV) & is_div_op(ex_aluop);
  assign div_signed_s = is_signed_div(ex_aluop);
  assign unused_s     = ^{ctrl_stall[5:STALL_EX_BIT+1], ctrl_stall[STALL_EX_BIT-1:0]};

  ex_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .is_signed (div_signed_s),
    .op_a      (ex_rdata1),
    .op_b      (ex_rdata2),
    .hold      (ctrl_stall[STALL_EX_BIT]),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quot_s),
    .remainder (div_rem_s)
  );

  // Result mux: group select first, then op within the group; anything undefined gives 0
  always_comb begin
    result_s = W_ZERO;
    case (ex_alusel)
      SEL_LOGIC: begin
        case (ex_aluop)
          ALUOP_AND: result_s = ex_rdata1 & ex_rdata2;
          ALUOP_OR:  result_s = ex_rdata1 | ex_rdata2;
          ALUOP_XOR: result_s = ex_rdata1 ^ ex_rdata2;
          default:   result_s = W_ZERO;
        endcase
      end
      SEL_SHIFT: begin
        case (ex_aluop)
          ALUOP_SLL: result_s = ex_rdata1 << shamt_s;
          ALUOP_SRL: result_s = ex_rdata1 >> shamt_s;
          ALUOP_SRA: result_s = $unsigned($signed(ex_rdata1) >>> shamt_s);
          default:   result_s = W_ZERO;
        endcase
      end
      SEL_ARITH: begin
        case (ex_aluop)
          ALUOP_ADD:  result_s = ex_rdata1 + ex_rdata2;
          ALUOP_SUB:  result_s = ex_rdata1 - ex_rdata2;
          ALUOP_SLT:  result_s = {{(DATA_W-1){1'b0}}, ($signed(ex_rdata1) < $signed(ex_rdata2))};
          ALUOP_SLTU: result_s = {{(DATA_W-1){1'b0}}, (ex_rdata1 < ex_rdata2)};
          default:    result_s = W_ZERO;
        endcase
      end
      SEL_DIV: begin
        if (div_done_s) begin
          case (ex_aluop)
            ALUOP_DIV, ALUOP_DIVU: result_s = div_quot_s;
            ALUOP_REM, ALUOP_REMU: result_s = div_rem_s;
            default:               result_s = W_ZERO;
          endcase
        end else begin
          result_s = W_ZERO;
        end
      end
      default: result_s = W_ZERO;
    endcase
  end

  // Reset forces every output to zero regardless of what ID/EX presents
  assign stall_req = rst & div_busy_s;
  assign mem_wdata = rst ? result_s : W_ZERO;
  assign mem_waddr = rst ? ex_waddr : 5'd0;
  assign mem_we    = rst & ex_we;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_rdata1;
  logic [31:0] ex_rdata2;
  logic [4:0]  ex_waddr;
  logic        ex_we;
  logic [5:0]  ctrl_stall;
  logic        stall_req;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_waddr;
  logic        mem_we;

  int checks   = 0;
  int failures = 0;

  ex_stage #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_aluop   (ex_aluop),
    .ex_alusel  (ex_alusel),
    .ex_rdata1  (ex_rdata1),
    .ex_rdata2  (ex_rdata2),
    .ex_waddr   (ex_waddr),
    .ex_we      (ex_we),
    .ctrl_stall (ctrl_stall),
    .stall_req  (stall_req),
    .mem_wdata  (mem_wdata),
    .mem_waddr  (mem_waddr),
    .mem_we     (mem_we)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference ALU: straight arithmetic on the operation meaning
  function automatic logic [31:0] model_alu(input logic [2:0] sel, input logic [7:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    if (sel == 3'd1 && op == 8'h03) return a & b;
    if (sel == 3'd1 && op == 8'h04) return a | b;
    if (sel == 3'd1 && op == 8'h05) return a ^ b;
    if (sel == 3'd2 && op == 8'h06) return a << sh;
    if (sel == 3'd2 && op == 8'h07) return a >> sh;
    if (sel == 3'd2 && op == 8'h08) return a[31] ? ~((~a) >> sh) : (a >> sh);
    if (sel == 3'd3 && op == 8'h01) return a + b;
    if (sel == 3'd3 && op == 8'h02) return a - b;
    if (sel == 3'd3 && op == 8'h09) return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
    if (sel == 3'd3 && op == 8'h0A) return (a < b) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  function automatic logic div_special(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ||
           ((op == 8'h10 || op == 8'h12) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference divider: truncating division, remainder takes dividend sign
  function automatic logic [31:0] model_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic   sgn;
    logic   want_rem;
    longint sa;
    longint sb;
    longint q;
    longint r;
    sgn      = (op == 8'h10) || (op == 8'h12);
    want_rem = (op == 8'h12) || (op == 8'h13);
    if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_rem ? 32'd0 : 32'h8000_0000;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return want_rem ? r[31:0] : q[31:0];
  endfunction

  task automatic alu_op(input string tag, input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [4:0] wa;
    logic       we;
    wa = 5'($urandom);
    we = 1'($urandom);
    ex_alusel = sel; ex_aluop = op; ex_rdata1 = a; ex_rdata2 = b;
    ex_waddr = wa; ex_we = we;
    #1;
    check_eq(tag, mem_wdata, model_alu(sel, op, a, b));
    check_eq({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
    check_eq({tag, "_waddr"}, {27'd0, mem_waddr}, {27'd0, wa});
    check_eq({tag, "_we"}, {31'd0, mem_we}, {31'd0, we});
    tick;
  endtask

  task automatic do_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold_cycles);
    int          n;
    int          exp_n;
    logic [31:0] exp_v;
    logic [4:0]  wa;
    wa = 5'($urandom);
    ex_alusel = SEL_DIV; ex_aluop = op; ex_rdata1 = a; ex_rdata2 = b;
    ex_waddr = wa; ex_we = 1'b1;
    #1;
    exp_n = div_special(op, a, b) ? 1 : 33;
    exp_v = model_div(op, a, b);
    n = 0;
    while (stall_req === 1'b1 && n < 80) begin
      n++;
      tick;
    end
    check_eq({tag, "_stall_cycles"}, n, exp_n);
    check_eq({tag, "_result"}, mem_wdata, exp_v);
    check_eq({tag, "_waddr"}, {27'd0, mem_waddr}, {27'd0, wa});
    if (hold_cycles > 0) begin
      ctrl_stall = 6'b001000;
      for (int i = 0; i < hold_cycles; i++) begin
        tick;
        check_eq({tag, "_hold_result"}, mem_wdata, exp_v);
        check_eq({tag, "_hold_nostall"}, {31'd0, stall_req}, 32'd0);
      end
      ctrl_stall = 6'b000000;
      tick;
      check_eq({tag, "_restart_after_release"}, {31'd0, stall_req}, 32'd1);
    end else begin
      tick;
    end
    ex_alusel = SEL_NOP; ex_aluop = ALUOP_NOP;
    #1;
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;

    rst = 1'b0;
    ctrl_stall = 6'd0;
    ex_aluop = ALUOP_DIV; ex_alusel = SEL_DIV;
    ex_rdata1 = 32'd100; ex_rdata2 = 32'd7;
    ex_waddr = 5'd9; ex_we = 1'b1;
    #12;
    check_eq("rst_stall", {31'd0, stall_req}, 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_waddr", {27'd0, mem_waddr}, 32'd0);
    check_eq("rst_we", {31'd0, mem_we}, 32'd0);
    ex_aluop = ALUOP_NOP; ex_alusel = SEL_NOP;
    @(negedge clk);
    rst = 1'b1;
    tick;

    // Directed ALU cases
    alu_op("add_wrap", SEL_ARITH, ALUOP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    alu_op("slt_neg", SEL_ARITH, ALUOP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    alu_op("sltu_big", SEL_ARITH, ALUOP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
    alu_op("sra_31", SEL_SHIFT, ALUOP_SRA, 32'h8000_0000, 32'd31);
    alu_op("nop", SEL_NOP, ALUOP_NOP, 32'h1234_5678, 32'h9ABC_DEF0);
    alu_op("bad_op", SEL_ARITH, 8'hFF, 32'h1234_5678, 32'h1);
    alu_op("bad_sel", 3'd7, ALUOP_ADD, 32'h1234_5678, 32'h1);

    // Directed divides
    do_div("div_m7_2", ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    do_div("rem_m7_2", ALUOP_REM, 32'hFFFF_FFF9, 32'd2, 0);
    do_div("divu_big", ALUOP_DIVU, 32'hFFFF_FFFF, 32'h10, 0);
    do_div("remu_big", ALUOP_REMU, 32'hFFFF_FFFF, 32'h10, 0);
    do_div("div_by0", ALUOP_DIV, 32'd5, 32'd0, 0);
    do_div("rem_by0", ALUOP_REM, 32'd5, 32'd0, 0);
    do_div("div_ovf", ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div("div_hold", ALUOP_DIV, 32'd1000, 32'hFFFF_FFFD, 4);
    do_div("b2b_a", ALUOP_DIVU, 32'd77, 32'd5, 0);
    do_div("b2b_b", ALUOP_REMU, 32'd77, 32'd5, 0);

    // Reset while iterating
    ex_alusel = SEL_DIV; ex_aluop = ALUOP_DIV;
    ex_rdata1 = 32'd1000; ex_rdata2 = 32'd3; ex_waddr = 5'd17; ex_we = 1'b1;
    #1;
    repeat (11) tick;
    check_eq("pre_rst_busy", {31'd0, stall_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_stall", {31'd0, stall_req}, 32'd0);
    check_eq("midrst_wdata", mem_wdata, 32'd0);
    check_eq("midrst_waddr", {27'd0, mem_waddr}, 32'd0);
    check_eq("midrst_we", {31'd0, mem_we}, 32'd0);
    repeat (2) @(posedge clk);
    ex_alusel = SEL_NOP; ex_aluop = ALUOP_NOP;
    #2 rst = 1'b1;
    #1;
    check_eq("postrst_idle", {31'd0, stall_req}, 32'd0);
    tick;
    do_div("postrst_div", ALUOP_DIV, 32'd1000, 32'd3, 0);

    // Random ALU traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 11))
        0:  begin sel = SEL_LOGIC; op = ALUOP_AND;  end
        1:  begin sel = SEL_LOGIC; op = ALUOP_OR;   end
        2:  begin sel = SEL_LOGIC; op = ALUOP_XOR;  end
        3:  begin sel = SEL_SHIFT; op = ALUOP_SLL;  end
        4:  begin sel = SEL_SHIFT; op = ALUOP_SRL;  end
        5:  begin sel = SEL_SHIFT; op = ALUOP_SRA;  end
        6:  begin sel = SEL_ARITH; op = ALUOP_ADD;  end
        7:  begin sel = SEL_ARITH; op = ALUOP_SUB;  end
        8:  begin sel = SEL_ARITH; op = ALUOP_SLT;  end
        9:  begin sel = SEL_ARITH; op = ALUOP_SLTU; end
        10: begin sel = SEL_SHIFT; op = ALUOP_ADD;  end
        default: begin sel = SEL_NOP; op = ALUOP_NOP; end
      endcase
      alu_op("rnd_alu", sel, op, $urandom, $urandom);
    end

    // Random divides, mixing small, full-range, zero and overflow divisors
    for (int i = 0; i < 16; i++) begin
      op = 8'h10 + 8'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'd0 - 32'($urandom_range(1, 20));
        3:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      do_div("rnd_div", op, a, b, (i % 5 == 0) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage: sits between the ID/EX pipeline register and the EX/MEM register. Computes the ALU result combinationally for single-cycle ops, and runs a radix-2 iterative divider for DIV/DIVU/REM/REMU. While dividing it raises `stall_req` to ctrl, which freezes the front of the pipe. Forwards the destination address and write enable to EX/MEM.

## Interface
- `DATA_W`, 32, operand/result width; divider iterations = DATA_W
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `ex_aluop`  in  8  operation code (`ALUOP_BUS`)
- `ex_alusel`  in  3  result-group select (`ALUSEL_BUS`)
- `ex_rdata1`  in  DATA_W  operand A / dividend
- `ex_rdata2`  in  DATA_W  operand B / divisor; shift amount is its low 5 bits
- `ex_waddr`  in  5  destination register
- `ex_we`  in  1  register write enable
- `ctrl_stall`  in  6  stall vector; bit 3 = EX frozen
- `stall_req`  out  1  request to ctrl: hold stages 0..3, bubble into MEM
- `mem_wdata`  out  DATA_W  result to EX/MEM
- `mem_waddr`  out  5  pass-through of `ex_waddr`
- `mem_we`  out  1  pass-through of `ex_we`

## Operation
- While `rst`=0: every output is 0, divider FSM is IDLE, counter is 0. This applies mid-divide too (abort, no result).
- ALU ops are combinational, with no state:
  - ADD 01, SUB 02, AND 03, OR 04, XOR 05 use wrap-around modulo 2^32.
  - SLL 06, SRL 07, SRA 08.
  - SLT 09 is signed; SLTU 0A is unsigned. Both produce 1 or 0.
  - NOP 00 gives result 0.
- alusel picks the result group: NOP 0, LOGIC 1, SHIFT 2, ARITH 3, DIV 4. An undefined aluop or alusel gives result 0.
- Divide ops: DIV 10, DIVU 11, REM 12, REMU 13.
- Divider FSM has three states: IDLE, BUSY, DONE.
  - IDLE + divide op: `stall_req`=1 combinationally. At the clock edge, latch |A|, |B|, the quotient sign (sA^sB for signed ops) and the remainder sign (sA). Clear the counter and go to BUSY.
  - IDLE + divisor 0, or signed overflow (A=0x80000000, B=0xFFFFFFFF): skip BUSY and go to DONE, with the result preset.
    - Divide by zero: quotient 0xFFFFFFFF, remainder = A.
    - Overflow: quotient 0x80000000, remainder 0.
  - BUSY: one restoring shift-subtract step per cycle; counter counts 0..DATA_W-1. At count DATA_W-1, apply sign correction and go to DONE. `stall_req`=1 throughout.
  - DONE: `stall_req`=0 and `mem_wdata` = the held quotient or remainder. Stay in DONE while `ctrl_stall[3]`=1. When `ctrl_stall[3]`=0 (EX/MEM captures this edge), return to IDLE.
- In IDLE with a non-divide op, `stall_req`=0.
- `mem_waddr` and `mem_we` always mirror the inputs; ID/EX holds them stable during the stall.
- Unsigned ops never sign-correct. The remainder sign follows the dividend.

## Timing
- ALU ops: zero latency, combinational input to output.
- Normal divide, op first visible at cycle 0:
  - `stall_req` is high for cycles 0..DATA_W (33 cycles).
  - DONE is in cycle DATA_W+1, and EX/MEM captures at the end of that cycle.
- Zero divisor or overflow: `stall_req` is high in cycle 0 only; DONE in cycle 1.
- Back-to-back divides: the second op is seen in IDLE one cycle after DONE and restarts the FSM normally.
- Downstream stall (`ctrl_stall[3]`=1) while in BUSY: iteration continues. DONE then holds until the stall releases.
- Reset asserting asynchronously mid-BUSY returns the FSM to IDLE immediately. After reset deasserts, the first edge follows normal rules.

## Structure
- Shared package / DEFINE file holds:
  - aluop and alusel codes.
  - `ALUOP_BUS`, `ALUSEL_BUS`, `REG_BUS`, `REG_ADDR_BUS`, `STALL_BUS`.
  - `ZERO_WORD`.
  - FSM state encodings DIV_IDLE/DIV_BUSY/DIV_DONE.
- One sub-module, `ex_div`, contains the FSM, counter, sign handling and special cases.
  - Interface: start, signed, op_a, op_b, hold, busy, done, quotient, remainder.
  - `ex_stage` instantiates it and keeps the ALU mux at top level.

## Test plan
- Reset mid-BUSY: after 10 BUSY cycles, pull `rst` low for 2 cycles → `stall_req`=0 and outputs 0 immediately; FSM is IDLE after release.
- ADD 0x7FFFFFFF+1 → 0x80000000; SLT -1,1 → 1; SLTU -1,1 → 0; SRA 0x80000000 by 31 → 0xFFFFFFFF. All with `stall_req`=0.
- DIV −7/2 → quotient 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF. `stall_req` high for exactly 33 cycles; result valid in cycle 33.
- DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF; REMU → 0xF.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with a 1-cycle stall. DIV 0x80000000/−1 → 0x80000000, 1-cycle stall.
- DONE with `ctrl_stall[3]`=1 for 4 cycles → result holds and `stall_req`=0; the next divide starts only after release.
